// File: rtl/led_blink_if.sv
// Event/level bundle between the game-result logic and the LED blink controller.
// The master drives the trigger pulses and the controller (slave) drives the light-stage levels.
interface led_blink_if;
    logic trig_win;
    logic trig_lose;
    logic blink;
    logic clk_blink;
    logic on;
    logic busy;

    modport master (
        output trig_win, trig_lose,
        input  blink, clk_blink, on, busy
    );

    modport slave (
        input  trig_win, trig_lose,
        output blink, clk_blink, on, busy
    );
endinterface

// File: rtl/led_blink_ctrl.sv
// Turns one-cycle win/lose pulses into blink, clk_blink and on levels for the 8-LED light stage.
// A win gives a timed blink burst and a loss gives a solid-on hold; the block is idle between events.
module led_blink_ctrl #(
    parameter int HALF_PERIOD = 12_500_000,
    parameter int BLINKS      = 4,
    parameter int HOLD_HALVES = 4
) (
    input  logic        clk,
    input  logic        rst,
    led_blink_if.slave  ctrlIf
);

    localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(HALF_PERIOD - 1);
    localparam logic [7:0]    WIN_HALVES = 8'(2 * BLINKS);
    localparam logic [7:0]    LOSE_HALVES = 8'(HOLD_HALVES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WIN  = 2'd1,
        LOSE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [7:0]     halfCnt_q, halfCnt_d;
    logic           blink_q, blink_d;
    logic           clkBlink_q, clkBlink_d;
    logic           on_q, on_d;
    logic           busy_q, busy_d;

    logic           tick;
    logic [7:0]     halfInc;

    assign tick    = (presc_q == PRESC_LAST);
    assign halfInc = halfCnt_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            halfCnt_q  <= '0;
            blink_q    <= 1'b0;
            clkBlink_q <= 1'b0;
            on_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            halfCnt_q  <= halfCnt_d;
            blink_q    <= blink_d;
            clkBlink_q <= clkBlink_d;
            on_q       <= on_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        halfCnt_d  = halfCnt_q;
        blink_d    = blink_q;
        clkBlink_d = clkBlink_q;

        case (state_q)
            IDLE: begin
                presc_d   = '0;
                halfCnt_d = '0;
                if (ctrlIf.trig_win) begin
                    state_d    = WIN;
                    blink_d    = 1'b1;
                    clkBlink_d = 1'b1;
                end else if (ctrlIf.trig_lose) begin
                    state_d    = LOSE;
                    blink_d    = 1'b1;
                    clkBlink_d = 1'b1;
                end
            end

            WIN: begin
                if (tick) begin
                    presc_d    = '0;
                    halfCnt_d  = halfInc;
                    clkBlink_d = ~clkBlink_q;
                    if (halfInc == WIN_HALVES) begin
                        state_d    = IDLE;
                        blink_d    = 1'b0;
                        clkBlink_d = 1'b0;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            LOSE: begin
                if (tick) begin
                    presc_d   = '0;
                    halfCnt_d = halfInc;
                    if (halfInc == LOSE_HALVES) begin
                        state_d    = IDLE;
                        blink_d    = 1'b0;
                        clkBlink_d = 1'b0;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            default: begin
                state_d    = IDLE;
                presc_d    = '0;
                halfCnt_d  = '0;
                blink_d    = 1'b0;
                clkBlink_d = 1'b0;
            end
        endcase
    end

    // One toggle per edge where either level changes, even if both change together.
    always_comb begin
        on_d   = on_q ^ ((blink_d != blink_q) | (clkBlink_d != clkBlink_q));
        busy_d = (state_d != IDLE);
    end

    assign ctrlIf.blink     = blink_q;
    assign ctrlIf.clk_blink = clkBlink_q;
    assign ctrlIf.on        = on_q;
    assign ctrlIf.busy      = busy_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl with HALF_PERIOD=4, BLINKS=2, HOLD_HALVES=3.
// Expected levels come from the hand-written edge timelines of each sequence.
module tb_led_blink_ctrl;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    logic expOn;

    led_blink_if bus ();

    led_blink_ctrl #(
        .HALF_PERIOD (4),
        .BLINKS      (2),
        .HOLD_HALVES (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ctrlIf (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation: {blink, clk_blink, on, busy}
    function automatic logic [3:0] observed();
        return {bus.blink, bus.clk_blink, bus.on, bus.busy};
    endfunction

    // Win burst: active after edges 0..15, clk_blink high in halves 0 and 2, on toggles at 0,4,8,12,16
    function automatic logic [3:0] winExp(input int k, input logic on0);
        logic act;
        logic clkb;
        int   toggles;
        act     = (k >= 0) && (k <= 15);
        clkb    = act && (((k / 4) % 2) == 0);
        toggles = (k >= 16) ? 5 : (k / 4 + 1);
        return {act, clkb, on0 ^ toggles[0], act};
    endfunction

    // Lose hold: active after edges 0..11, on toggles at 0 and 12
    function automatic logic [3:0] loseExp(input int k, input logic on0);
        logic act;
        int   toggles;
        act     = (k <= 11);
        toggles = (k >= 12) ? 2 : 1;
        return {act, act, on0 ^ toggles[0], act};
    endfunction

    task automatic applyStimulus(input logic win, input logic lose);
        bus.trig_win  = win;
        bus.trig_lose = lose;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called between a negedge and the next posedge; that posedge is edge 0.
    task automatic runBurst(input string tag, input logic win, input logic lose,
                            input int loseAt, input bit hold, input int nEdges, input bit expWin);
        logic       on0;
        logic [3:0] exp;
        on0 = expOn;
        applyStimulus(win, lose);
        for (int k = 0; k < nEdges; k++) begin
            @(posedge clk);
            #1;
            if (hold) begin
                if (k == nEdges - 1) applyStimulus(1'b0, 1'b0);
            end else begin
                if (k == 0)          applyStimulus(1'b0, 1'b0);
                if (k + 1 == loseAt) applyStimulus(1'b0, 1'b1);
                if (k == loseAt)     applyStimulus(1'b0, 1'b0);
            end
            @(negedge clk);
            if (!expWin)
                exp = loseExp(k, on0);
            else if (hold && k >= 17)
                exp = winExp(k - 17, ~on0);
            else
                exp = winExp(k, on0);
            checkOutput($sformatf("%s k=%0d", tag, k), {28'b0, observed()}, {28'b0, exp});
            expOn = exp[1];
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        expOn      = 1'b0;
        rst        = 1'b1;
        applyStimulus(1'b0, 1'b0);

        #1;
        checkOutput("reset_no_clock", {28'b0, observed()}, 32'h0);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("idle_20_cycles", {28'b0, observed()}, 32'h0);

        runBurst("win", 1'b1, 1'b0, -1, 1'b0, 20, 1'b1);
        runBurst("lose", 1'b0, 1'b1, -1, 1'b0, 16, 1'b0);
        runBurst("both_then_lose5", 1'b1, 1'b1, 5, 1'b0, 20, 1'b1);

        runBurst("win_pre_reset", 1'b1, 1'b0, -1, 1'b0, 6, 1'b1);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid_reset", {28'b0, observed()}, 32'h0);
        expOn = 1'b0;
        #1 rst = 1'b0;
        runBurst("win_after_reset", 1'b1, 1'b0, -1, 1'b0, 20, 1'b1);

        runBurst("win_held", 1'b1, 1'b0, -1, 1'b1, 34, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("idle_after_held", {28'b0, observed()}, {28'b0, 2'b00, expOn, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
